// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared sizing helpers for the host message <-> AXIL word bridges.
// The read-side serializer and the write-side mirror block both use them.
package blackparrot_fpga_host_pkg;

   function automatic int words_per_msg(input int msg_w, input int word_w);
      return msg_w / word_w;
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int occ_width(input int els);
      return $clog2(els + 1);
   endfunction

   typedef enum logic {S_IDLE, S_SEND} ser_state_e;

endpackage

// File: rtl/blackparrot_fpga_host_word_fifo.sv
// Word FIFO storage with a combinational head. Occupancy lives in the parent,
// so a write into a full FIFO is legal when it coincides with a dequeue.
module blackparrot_fpga_host_word_fifo #(
   parameter int WIDTH = 32,
   parameter int ELS   = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enq_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             deq_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int PTR_W = (ELS > 1) ? $clog2(ELS) : 1;

   logic [WIDTH-1:0] mem [ELS];
   logic [PTR_W-1:0] wptr_r, rptr_r;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(ELS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign data_o = mem[rptr_r];

   // When full, wptr == rptr: the head is read before the edge overwrites it.
   always_ff @(posedge clk_i) begin
      if (enq_i) mem[wptr_r] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (enq_i) wptr_r <= ptr_inc(wptr_r);
         if (deq_i) rptr_r <= ptr_inc(rptr_r);
      end
   end

endmodule

// File: rtl/blackparrot_fpga_host_msg_to_fifo.sv
// Serializes wide host-bound messages into AXIL-width words (lowest first),
// buffers them in a word FIFO, and reports FIFO occupancy on a second channel.
module blackparrot_fpga_host_msg_to_fifo
   import blackparrot_fpga_host_pkg::*;
#(
   parameter int S_AXIL_DATA_WIDTH = 32,
   parameter int MSG_WIDTH         = 64,
   parameter int FIFO_ELS          = 8
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [MSG_WIDTH-1:0]         msg_i,
   input  logic                         msg_v_i,
   output logic                         msg_ready_and_o,
   output logic                         fifo_v_o,
   output logic [S_AXIL_DATA_WIDTH-1:0] fifo_data_o,
   input  logic                         fifo_yumi_i,
   output logic                         count_v_o,
   output logic [S_AXIL_DATA_WIDTH-1:0] count_data_o,
   input  logic                         count_yumi_i
);

   localparam int W     = S_AXIL_DATA_WIDTH;
   localparam int N     = words_per_msg(MSG_WIDTH, W);
   localparam int IDX_W = idx_width(N);
   localparam int OCC_W = occ_width(FIFO_ELS);

   ser_state_e           state_r, state_n;
   logic [IDX_W-1:0]     k_r, k_n;
   logic [MSG_WIDTH-1:0] msg_r, msg_n;
   logic [OCC_W-1:0]     occ_r, occ_n;
   logic [N-1:0][W-1:0]  msg_words;
   logic                 enq, deq, last, accept;

   assign msg_words = msg_r;

   always_comb begin
      state_n = state_r;
      k_n     = k_r;
      msg_n   = msg_r;
      // Full-with-yumi bypass: the slot freed this cycle takes the new word.
      enq     = (state_r == S_SEND) && ((occ_r < OCC_W'(FIFO_ELS)) || fifo_yumi_i);
      deq     = fifo_yumi_i & fifo_v_o;
      last    = enq && (k_r == IDX_W'(N - 1));
      msg_ready_and_o = ~reset_i & ((state_r == S_IDLE) | last);
      accept  = msg_v_i & msg_ready_and_o;
      if (enq)  k_n = k_r + IDX_W'(1);
      if (last) state_n = S_IDLE;
      if (accept) begin
         state_n = S_SEND;
         k_n     = '0;
         msg_n   = msg_i;
      end
      unique case ({enq, deq})
         2'b10:   occ_n = occ_r + OCC_W'(1);
         2'b01:   occ_n = occ_r - OCC_W'(1);
         default: occ_n = occ_r;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= S_IDLE;
         k_r     <= '0;
         occ_r   <= '0;
      end else begin
         state_r <= state_n;
         k_r     <= k_n;
         occ_r   <= occ_n;
      end
   end

   always_ff @(posedge clk_i) msg_r <= msg_n;

   assign fifo_v_o     = ~reset_i & (occ_r != '0);
   assign count_v_o    = ~reset_i;
   assign count_data_o = W'(occ_r);

   blackparrot_fpga_host_word_fifo #(.WIDTH(W), .ELS(FIFO_ELS)) word_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_i   (enq),
      .data_i  (msg_words[k_r]),
      .deq_i   (deq),
      .data_o  (fifo_data_o)
   );

   logic unused_count_yumi;
   assign unused_count_yumi = count_yumi_i;

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      fifo_yumi_i |-> fifo_v_o);
   a_msg_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (msg_v_i && !msg_ready_and_o) |=> $stable(msg_i));

endmodule

// File: tb/tb_blackparrot_fpga_host_msg_to_fifo.sv
// Randomized scoreboard bench for the message-to-word-FIFO serializer.
module tb_blackparrot_fpga_host_msg_to_fifo;

   localparam int W   = 32;
   localparam int MW  = 64;
   localparam int ELS = 4;
   localparam int N   = MW / W;

   logic          clk_i = 0;
   logic          reset_i = 1;
   logic [MW-1:0] msg_i = '0;
   logic          msg_v_i = 0;
   logic          msg_ready_and_o;
   logic          fifo_v_o;
   logic [W-1:0]  fifo_data_o;
   logic          fifo_yumi_i = 0;
   logic          count_v_o;
   logic [W-1:0]  count_data_o;
   logic          count_yumi_i = 0;

   blackparrot_fpga_host_msg_to_fifo #(
      .S_AXIL_DATA_WIDTH(W), .MSG_WIDTH(MW), .FIFO_ELS(ELS)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .msg_i(msg_i), .msg_v_i(msg_v_i),
      .msg_ready_and_o(msg_ready_and_o), .fifo_v_o(fifo_v_o),
      .fifo_data_o(fifo_data_o), .fifo_yumi_i(fifo_yumi_i),
      .count_v_o(count_v_o), .count_data_o(count_data_o),
      .count_yumi_i(count_yumi_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   // Reference model: words still to be serialized from the captured message,
   // words sitting in the FIFO, and the expected word order.
   int            occ = 0;
   int            wl = 0;
   int            yumi_pct = 100;
   logic [W-1:0]  exp_q[$];
   logic [MW-1:0] msg_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst);
      bit enq, exp_ready;
      @(negedge clk_i);
      reset_i = rst;
      fifo_yumi_i = !rst && fifo_v_o && ($urandom_range(99) < yumi_pct);
      count_yumi_i = 1'($urandom_range(1));
      if (!rst && msg_q.size() > 0) begin
         msg_v_i = 1;
         msg_i   = msg_q[0];
      end else begin
         msg_v_i = 0;
         msg_i   = {$urandom, $urandom};
      end
      #1;
      if (rst) begin
         chk("rst_ready", msg_ready_and_o, 0);
         chk("rst_count_v", count_v_o, 0);
         occ = 0;
         wl = 0;
         exp_q.delete();
         msg_q.delete();
      end else begin
         enq = (wl > 0) && (occ < ELS || fifo_yumi_i);
         exp_ready = (wl == 0) || (wl == 1 && enq);
         chk("ready", msg_ready_and_o, exp_ready);
         chk("count_data", count_data_o, occ);
         chk("fifo_v", fifo_v_o, occ != 0);
         chk("count_v", count_v_o, 1);
         chk("occ_bound", count_data_o <= ELS, 1);
         occ = occ + int'(enq) - int'(fifo_yumi_i);
         if (enq) wl--;
         if (msg_v_i && exp_ready) begin
            wl = N;
            for (int i = 0; i < N; i++) exp_q.push_back(msg_i[i*W +: W]);
            void'(msg_q.pop_front());
         end
      end
   endtask

   task automatic drain();
      int n;
      yumi_pct = 100;
      n = 0;
      while ((msg_q.size() > 0 || wl > 0 || occ > 0) && n < 200) begin
         step(0);
         n++;
      end
      chk("drain_timeout", n < 200, 1);
      step(0);
      chk("drain_exp_empty", exp_q.size(), 0);
   endtask

   // Monitor: compares each dequeued word against the scoreboard head.
   always @(negedge clk_i) begin
      #2;
      if (!reset_i && fifo_yumi_i) begin
         if (exp_q.size() == 0) chk("unexpected_word", fifo_data_o, 'x);
         else chk("word", fifo_data_o, exp_q.pop_front());
      end
   end

   initial begin
      int n;
      // reset state
      step(1);
      step(1);
      chk("reset_fifo_v", fifo_v_o, 0);
      chk("reset_count", count_data_o, 0);
      step(0);

      // single message
      msg_q.push_back(64'h1111_2222_3333_4444);
      drain();

      // back-to-back, consumer always ready
      for (int i = 0; i < 3; i++) msg_q.push_back({$urandom, $urandom});
      drain();

      // full stall then a single yumi through the bypass
      yumi_pct = 0;
      for (int i = 0; i < 3; i++) msg_q.push_back({$urandom, $urandom});
      repeat (8) step(0);
      chk("stall_count", count_data_o, ELS);
      chk("stall_ready", msg_ready_and_o, 0);
      chk("stall_wl", wl, N);
      yumi_pct = 100;
      step(0);
      yumi_pct = 0;
      step(0);
      chk("bypass_count", count_data_o, ELS);
      drain();

      // wrap-around under random backpressure
      yumi_pct = 50;
      for (int i = 0; i < 20; i++) msg_q.push_back({$urandom, $urandom});
      n = 0;
      while (msg_q.size() > 0 && n < 500) begin
         step(0);
         n++;
      end
      chk("random_timeout", n < 500, 1);
      drain();

      // reset mid-message with three words buffered
      yumi_pct = 0;
      msg_q.push_back({$urandom, $urandom});
      msg_q.push_back({$urandom, $urandom});
      n = 0;
      while (!(occ == 3 && wl == 1) && n < 20) begin
         step(0);
         n++;
      end
      chk("midrst_setup", n < 20, 1);
      step(1);
      step(1);
      chk("midrst_fifo_v", fifo_v_o, 0);
      chk("midrst_count", count_data_o, 0);
      msg_q.push_back({$urandom, $urandom});
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
